// File: rtl/btn_pkg.sv
// Shared constants for the push-button status word: field offsets, reset value and a packing helper.
// Pure package with no latency, flow control or state.
package btn_pkg;

   localparam int          NBTN_MAX   = 8;
   localparam int          LVL_LSB    = 0;
   localparam int          PRESS_LSB  = 8;
   localparam int          REL_LSB    = 16;
   localparam logic [31:0] STATUS_RST = 32'h0;

   function automatic logic [31:0] pack_status(input logic [NBTN_MAX-1:0] lvl,
                                               input logic [NBTN_MAX-1:0] press_flg,
                                               input logic [NBTN_MAX-1:0] rel_flg);
      logic [31:0] w;
      w = STATUS_RST;
      w[LVL_LSB   +: NBTN_MAX] = lvl;
      w[PRESS_LSB +: NBTN_MAX] = press_flg;
      w[REL_LSB   +: NBTN_MAX] = rel_flg;
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, stability counter and debounced level.
// rise/fall are combinational acceptance strobes valid in the cycle before lvl flips; no backpressure.
module btn_debounce_ch #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic lvl,
   output logic rise,
   output logic fall
);

   localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic          accept;

   always_comb begin
      accept = (s2 != lvl) && (cnt == CNT_MAX);
      rise   = accept & s2;
      fall   = accept & ~s2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         cnt <= '0;
         lvl <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         // Any sample matching the current level restarts the stability window.
         if (s2 == lvl) begin
            cnt <= '0;
         end else if (accept) begin
            lvl <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_debounce.sv
// Debounces NBTN buttons into a sticky press/release status word plus one-cycle press pulses.
// Latency DEBOUNCE_CYCLES+2 edges from raw edge to wdata/press; no backpressure, clr always accepted.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int NBTN            = 5,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NBTN-1:0] btn,
   input  logic            clr,
   input  logic [NBTN-1:0] clr_mask,
   output logic [31:0]     wdata,
   output logic [NBTN-1:0] press
);

   logic [NBTN-1:0] lvl;
   logic [NBTN-1:0] rise;
   logic [NBTN-1:0] fall;
   logic [NBTN-1:0] lvl_nxt;
   logic [NBTN-1:0] clr_sel;
   logic [NBTN-1:0] press_flg;
   logic [NBTN-1:0] rel_flg;
   logic [NBTN-1:0] press_flg_nxt;
   logic [NBTN-1:0] rel_flg_nxt;

   for (genvar i = 0; i < NBTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .btn  (btn[i]),
         .lvl  (lvl[i]),
         .rise (rise[i]),
         .fall (fall[i])
      );
   end

   // Set is OR-ed in after the clear so an event landing with a clear is never lost.
   always_comb begin
      clr_sel       = clr ? clr_mask : '0;
      lvl_nxt       = (lvl | rise) & ~fall;
      press_flg_nxt = (press_flg & ~clr_sel) | rise;
      rel_flg_nxt   = (rel_flg & ~clr_sel) | fall;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         press_flg <= '0;
         rel_flg   <= '0;
         press     <= '0;
         wdata     <= STATUS_RST;
      end else begin
         press_flg <= press_flg_nxt;
         rel_flg   <= rel_flg_nxt;
         press     <= rise;
         wdata     <= pack_status(NBTN_MAX'(lvl_nxt), NBTN_MAX'(press_flg_nxt),
                                  NBTN_MAX'(rel_flg_nxt));
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with NBTN=5, DEBOUNCE_CYCLES=4: directed table, corner sequences, random vs model.
module tb_btn_debounce;

   localparam int NB = 5;
   localparam int DC = 4;

   logic          clk;
   logic          rst;
   logic [NB-1:0] btn;
   logic          clr;
   logic [NB-1:0] clr_mask;
   logic [31:0]   wdata;
   logic [NB-1:0] press;

   int checks = 0;
   int errors = 0;

   btn_debounce #(.NBTN(NB), .DEBOUNCE_CYCLES(DC)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn),
      .clr      (clr),
      .clr_mask (clr_mask),
      .wdata    (wdata),
      .press    (press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: raw samples reach the comparison point two edges late; a level is
   // accepted once the last DC delayed samples all disagree with the current level.
   logic [NB-1:0] m_d1, m_d2, m_s2;
   logic [NB-1:0] win[$];
   logic [NB-1:0] m_lvl, m_pflg, m_rflg, m_press, m_rise, m_fall, m_clr;
   bit            m_all;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_d1 = '0; m_d2 = '0; win.delete();
         m_lvl = '0; m_pflg = '0; m_rflg = '0; m_press = '0;
      end else begin
         m_s2 = m_d2;
         m_d2 = m_d1;
         m_d1 = btn;
         win.push_back(m_s2);
         if (win.size() > DC) void'(win.pop_front());
         m_rise = '0;
         m_fall = '0;
         for (int ch = 0; ch < NB; ch++) begin
            m_all = (win.size() == DC);
            foreach (win[j]) if (win[j][ch] == m_lvl[ch]) m_all = 0;
            if (m_all) begin
               if (m_lvl[ch]) m_fall[ch] = 1'b1;
               else           m_rise[ch] = 1'b1;
            end
         end
         m_clr   = clr ? clr_mask : '0;
         m_pflg  = (m_pflg & ~m_clr) | m_rise;
         m_rflg  = (m_rflg & ~m_clr) | m_fall;
         m_lvl   = m_lvl ^ (m_rise | m_fall);
         m_press = m_rise;
      end
   end

   function automatic logic [31:0] model_word();
      return {11'b0, m_rflg, 3'b0, m_pflg, 3'b0, m_lvl};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge: drive inputs, advance over one posedge to the next negedge.
   task automatic cyc(input logic [NB-1:0] b, input logic c, input logic [NB-1:0] m);
      btn = b; clr = c; clr_mask = m;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; btn = '0; clr = 1'b0; clr_mask = '0;
   endtask

   typedef struct {
      logic [NB-1:0] b;
      logic          c;
      logic [NB-1:0] m;
      logic [31:0]   w;
      logic [NB-1:0] p;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [NB-1:0] b, input logic c, input logic [NB-1:0] m,
                               input logic [31:0] w, input logic [NB-1:0] p);
      vec_t v;
      v.b = b; v.c = c; v.m = m; v.w = w; v.p = p;
      tbl.push_back(v);
   endfunction

   initial begin
      rst = 1'b1; btn = '1; clr = 1'b0; clr_mask = '0;
      #1 rst = 1'b0;

      // Reset values while held in reset with all buttons pressed.
      repeat (2) @(negedge clk);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_press", 32'(press), 32'h0);

      // Buttons held through reset release: accepted on the sixth edge.
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(5'h1F, 1'b0, 5'h00);
         chk($sformatf("hold_wdata_e%0d", i), wdata, 32'h0);
      end
      cyc(5'h1F, 1'b0, 5'h00);
      chk("hold_accept_wdata", wdata, 32'h0000_1F1F);
      chk("hold_accept_press", 32'(press), 32'h1F);
      cyc(5'h1F, 1'b0, 5'h00);
      chk("hold_press_drop", 32'(press), 32'h0);
      chk("hold_wdata_keep", wdata, 32'h0000_1F1F);

      // Directed table: clean press/release on btn[2], masked clears, glitch on btn[0].
      for (int i = 0; i < 5; i++) add(5'h04, 0, 5'h00, 32'h0, 5'h00);
      add(5'h04, 0, 5'h00, 32'h0000_0404, 5'h04);
      add(5'h04, 0, 5'h00, 32'h0000_0404, 5'h00);
      for (int i = 0; i < 5; i++) add(5'h00, 0, 5'h00, 32'h0000_0404, 5'h00);
      add(5'h00, 0, 5'h00, 32'h0004_0400, 5'h00);
      add(5'h00, 0, 5'h00, 32'h0004_0400, 5'h00);
      add(5'h00, 1, 5'h02, 32'h0004_0400, 5'h00);
      add(5'h00, 1, 5'h00, 32'h0004_0400, 5'h00);
      add(5'h00, 1, 5'h04, 32'h0000_0000, 5'h00);
      for (int i = 0; i < 3; i++) add(5'h01, 0, 5'h00, 32'h0, 5'h00);
      for (int i = 0; i < 6; i++) add(5'h00, 0, 5'h00, 32'h0, 5'h00);

      pulse_reset();
      foreach (tbl[i]) begin
         cyc(tbl[i].b, tbl[i].c, tbl[i].m);
         chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].w);
         chk($sformatf("tbl%0d_press", i), 32'(press), 32'(tbl[i].p));
      end

      // Masked clear leaves other channels alone; set and clear in one cycle keeps the flag.
      repeat (6) cyc(5'h04, 1'b0, 5'h00);
      repeat (6) cyc(5'h00, 1'b0, 5'h00);
      repeat (6) cyc(5'h04, 1'b0, 5'h00);
      chk("mc_setup_a", wdata, 32'h0004_0404);
      repeat (6) cyc(5'h06, 1'b0, 5'h00);
      chk("mc_setup_b", wdata, 32'h0004_0606);
      cyc(5'h06, 1'b1, 5'h04);
      chk("mc_clear_ch2", wdata, 32'h0000_0206);
      repeat (5) cyc(5'h0E, 1'b0, 5'h00);
      cyc(5'h0E, 1'b1, 5'h08);
      chk("set_wins_wdata", wdata, 32'h0000_0A0E);
      chk("set_wins_press", 32'(press), 32'h08);
      cyc(5'h0E, 1'b1, 5'h08);
      chk("clear_after_set", wdata, 32'h0000_020E);

      // Reset during a debounce discards the partial count.
      pulse_reset();
      cyc(5'h00, 1'b0, 5'h00);
      cyc(5'h10, 1'b0, 5'h00);
      cyc(5'h10, 1'b0, 5'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_wdata", wdata, 32'h0);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(5'h10, 1'b0, 5'h00);
         chk($sformatf("mid_rst_e%0d", i), wdata | 32'(press), 32'h0);
      end
      cyc(5'h10, 1'b0, 5'h00);
      chk("mid_rst_accept", wdata, 32'h0000_1010);
      chk("mid_rst_press", 32'(press), 32'h10);

      // Random bouncing inputs and clears against the reference model.
      pulse_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) rst = 1'b0;
         else           rst = 1'b1;
         if ($urandom_range(0, 5) == 0) btn = btn ^ NB'($urandom);
         clr      = ($urandom_range(0, 7) == 0);
         clr_mask = NB'($urandom);
         @(negedge clk);
         chk($sformatf("rnd%0d_wdata", i), wdata, model_word());
         chk($sformatf("rnd%0d_press", i), 32'(press), 32'(m_press));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces the five board push-buttons and produces the 32-bit button status word that the data RAM exposes to the MIPS core as its memory-mapped button register. It sits between the raw `btn` pins and the RAM's button-data input, in the `clk0` domain. It provides:
- debounced button levels;
- sticky press and release event flags, clearable by the RAM side;
- single-cycle press pulses for local use.

## Interface
Parameters:
- `NBTN`, 5: number of button channels (max 8).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required to accept a level change. Default is 10 ms at 50 MHz. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock (`clk0`).
- `rst`  in  1  reset; asynchronous, active-low.
- `btn`  in  NBTN  raw, asynchronous button inputs; 1 = pressed.
- `clr`  in  1  single-cycle request to clear sticky event bits.
- `clr_mask`  in  NBTN  per-channel select for `clr`. A bit clears both the press and release flag of that channel.
- `wdata`  out  32  status word, registered.
- `press`  out  NBTN  one-cycle pulse per accepted press.

## Operation
- Per channel:
  - 2-FF synchronizer `s1 -> s2`.
  - Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
  - Debounced level `lvl`.
- Each cycle:
  - If `s2 == lvl`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then:
    - `lvl <= s2`;
    - `cnt <= 0`;
    - set the sticky press flag (`lvl` 0->1) or release flag (1->0);
    - for a press, assert `press` for exactly that one cycle.
  - Else `cnt <= cnt + 1`.
- Glitches shorter than `DEBOUNCE_CYCLES` samples never change `lvl`. Any sample equal to `lvl` restarts the count.
- Sticky flags hold until cleared by `clr` with the corresponding `clr_mask` bit. `clr` with an all-zero mask is a no-op.
- Simultaneous set and clear on the same channel in the same cycle: set wins, so no event is lost.
- `wdata` layout:
  - [NBTN-1:0] = `lvl`;
  - [8+NBTN-1:8] = press flags;
  - [16+NBTN-1:16] = release flags;
  - all other bits 0.
- Reset (`rst` low): `s1`, `s2`, `cnt`, `lvl`, all flags, `press` and `wdata` clear to 0 immediately. Reset mid-debounce discards the partial count.
- A button held through reset release is debounced to 1 normally and produces one press event.

## Timing
- All state updates on rising `clk`. Reset is applied asynchronously and released synchronously by the top level.
- Let edge 0 be the first edge that samples a new raw level held stable:
  - `s2` updates at edge 1.
  - `lvl`, the flag and `press` update at edge `DEBOUNCE_CYCLES+1`.
  - Latency is therefore `DEBOUNCE_CYCLES+2` edges, counting edge 0.
- `wdata` is registered from the next-state values, so it changes at the same edge as `lvl` and the flags. No extra cycle is added.
- Clear: `clr` high at edge n means the flag reads 0 after edge n, unless it is re-set at edge n.
- `press` is high for one cycle per accepted press. It is never asserted for release events.
- Channels are fully independent. Simultaneous events on several channels are all captured in the same cycle.
- The counter never wraps: it is bounded by `DEBOUNCE_CYCLES-1` and resets on acceptance.

## Structure
- Package `btn_pkg`:
  - `NBTN_MAX` = 8;
  - field offsets `LVL_LSB` = 0, `PRESS_LSB` = 8, `REL_LSB` = 16;
  - reset value of the status word, 32'h0.
- Sub-module `btn_debounce_ch`:
  - one channel: synchronizer, counter, `lvl`, edge detect;
  - outputs `lvl`, `rise`, `fall`;
  - instantiated `NBTN` times by generate.
- The top holds the sticky flag registers, clear logic and `wdata` packing.

## Test plan
Benches use `DEBOUNCE_CYCLES` = 4 and `NBTN` = 5.
- Reset values: with `rst` low, `btn` = 5'h1F -> `wdata` = 0 and `press` = 0. Release reset with `btn` held -> after 6 edges `wdata` = 32'h0000_1F1F, and `press` = 5'h1F for one cycle.
- Glitch rejection: `btn[0]` high for 3 cycles then low -> `wdata` stays 0 and `press` never asserts.
- Clean press and release on `btn[2]`:
  - high at edge 0 -> `wdata` = 32'h0000_0404 after edge 5, with `press[2]` pulsing once;
  - then low for 6+ edges -> `wdata` = 32'h0004_0400.
- Masked clear: from 32'h0004_0404 + press flag bit 1, issue `clr` with `clr_mask` = 5'h04 -> only bits 10 and 18 clear, leaving 32'h0000_0204 (assuming `lvl[2]` = 1). Same-cycle set plus clear on a channel -> flag stays 1.
- Reset mid-debounce: `btn[4]` high, `rst` pulsed low at edge 2 -> `cnt` cleared. The press is accepted only 6 edges after reset release.
